if_id_skid_reg: RTL and testbench
=================================

Name: if_id_skid_reg

Overview:
Parametrised IF/ID pipeline register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush, and a saturating stall-cycle counter. It sits between the fetch unit and the decoder and replaces the plain always-load IF/ID register. Fetch can run at full throughput. Decode can back-pressure without a combinational ready path to fetch. Branch resolution can squash in-flight instructions.

Parameters:
PC_W, 32, PC field width in bits
INSTR_W, 32, instruction field width in bits
NOP_INSTR, 32'h0000_0013, instruction word presented when the output is invalid (ADDI x0,x0,0); width INSTR_W
STALL_CNT_W, 16, stall-counter width in bits

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
in_valid  in  1  fetch presents a beat
in_ready  out  1  register accepts a beat; driven directly from a flop
in_pc  in  PC_W  PC of the fetched instruction
in_instr  in  INSTR_W  fetched instruction word
flush  in  1  synchronous squash of all held and incoming beats
out_valid  out  1  decode-side beat valid
out_ready  in  1  decode accepts the beat
out_pc  out  PC_W  PC of the head beat
out_instr  out  INSTR_W  instruction of the head beat; NOP_INSTR when out_valid=0
stall_count  out  STALL_CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately): out_valid=0, out_pc=0, out_instr=NOP_INSTR, in_ready=1, stall_count=0, skid entry invalid, state=EMPTY.
- Handshake rules:
  - Input accepted when in_valid & in_ready at the clock edge.
  - Output consumed when out_valid & out_ready at the clock edge.
  - in_valid and the input data need not be held stable while in_ready=0.
- Storage: head register (drives out_*) and skid register. in_ready = !skid_valid, registered.
- State machine; transitions at the rising edge of clk:
  - EMPTY:
    - Input accepted -> head <= input, go to BUSY.
    - No input -> stay in EMPTY.
  - BUSY:
    - Accept and consume -> head <= input, stay in BUSY.
    - Accept, no consume -> skid <= input, go to FULL, in_ready becomes 0.
    - Consume, no accept -> go to EMPTY.
    - Neither -> hold.
  - FULL (in_ready=0, no input accepted):
    - Consume -> head <= skid, skid invalidated, go to BUSY, in_ready becomes 1.
    - No consume -> hold.
- Latency and ordering:
  - Latency is 1 cycle from input accept to out_valid when the path is empty.
  - Sustained throughput is 1 beat/cycle.
  - Beats are delivered in strict acceptance order, never duplicated or dropped except by flush.
- Flush (synchronous, highest priority over every other transition):
  - At the edge where flush=1: head and skid are invalidated, state goes to EMPTY, in_ready becomes 1.
  - Any beat offered or accepted in that cycle is discarded.
  - Next cycle: out_valid=0, out_instr=NOP_INSTR.
  - out_pc holds its last value and is don't-care while out_valid=0.
- out_instr = out_valid ? head_instr : NOP_INSTR, for every state including EMPTY.
- stall_count:
  - Increments by 1 at each edge where out_valid=1 and out_ready=0.
  - Saturates at all-ones and never wraps.
  - Unaffected by flush; cleared only by rst.
- Reset asserted mid-operation: all entries are lost immediately, regardless of clk, and outputs return to their reset values. Normal operation resumes at the first edge after rst deasserts.

Test Plan:
- Reset:
  - Drive rst=0 for 2 cycles with in_valid=1 -> out_valid=0, out_instr=00000013, out_pc=0, in_ready=1, stall_count=0.
  - No beat is accepted during reset.
- Single beat:
  - With out_ready=1, present pc=0x4, instr=00500093 for one cycle -> next cycle out_valid=1, out_pc=0x4, out_instr=00500093.
  - The cycle after that: out_valid=0, out_instr=00000013.
- Streaming with back-pressure:
  - Send pc 0x4/00500093, 0x8/00108133, 0xC/00000013 back-to-back with out_ready=0 from cycle 2.
  - -> in_ready drops to 0 after two beats accepted; stall_count increments each stalled cycle.
  - Raise out_ready -> beats emerge in order 0x4, 0x8, then 0xC with no loss or duplication.
- Flush in FULL:
  - With both entries valid and in_valid=1, pulse flush for 1 cycle -> next cycle out_valid=0, out_instr=00000013, in_ready=1.
  - The offered beat never appears at the output.
- Counter saturation:
  - With STALL_CNT_W=4, hold a valid beat with out_ready=0 for 20 cycles -> stall_count reads 15 and stays at 15.
- Asynchronous reset mid-stream:
  - Assert rst=0 between clock edges while in FULL -> outputs reach reset values before the next edge.
  - After release, a new beat pc=0x10 appears with 1-cycle latency.

Source files
------------

// File: rtl/if_id_skid_reg_if.sv
// IF/ID beat interface: valid/ready handshake carrying a PC and an instruction word.
// Latency: none (wires only).
// Backpressure: the slave deasserts ready; the master may change valid/data while ready=0.
interface if_id_skid_reg_if #(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32
);
   logic               valid;
   logic               ready;
   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] instr;

   modport master (output valid, output pc, output instr, input  ready);
   modport slave  (input  valid, input  pc, input  instr, output ready);
endinterface

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer, sync flush and saturating stall counter.
// Latency: 1 cycle from input accept to out valid; 1 beat/cycle sustained.
// Backpressure: in ready is a flop (low only while the skid entry is occupied), no comb path from out ready.
module if_id_skid_reg #(
   parameter int                 PC_W        = 32,
   parameter int                 INSTR_W     = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR   = 32'h0000_0013,
   parameter int                 STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   if_id_skid_reg_if.slave        in_if,
   if_id_skid_reg_if.master       out_if,
   input  logic                   flush,
   output logic [STALL_CNT_W-1:0] stall_count
);

   // EMPTY: nothing held; BUSY: head only; FULL: head and skid both held.
   typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_e;

   state_e                 state_q, state_d;
   logic [PC_W-1:0]        head_pc_q, head_pc_d;
   logic [INSTR_W-1:0]     head_instr_q, head_instr_d;
   logic [PC_W-1:0]        skid_pc_q, skid_pc_d;
   logic [INSTR_W-1:0]     skid_instr_q, skid_instr_d;
   logic                   in_rdy_q, in_rdy_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic out_vld;
   logic acc;
   logic cons;

   assign out_vld = (state_q != EMPTY);
   assign acc     = in_if.valid & in_rdy_q;
   assign cons    = out_vld & out_if.ready;

   // Next-state, datapath loads and stall counter; flush overrides every transition.
   always_comb begin
      state_d      = state_q;
      head_pc_d    = head_pc_q;
      head_instr_d = head_instr_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      in_rdy_d     = in_rdy_q;
      stall_cnt_d  = stall_cnt_q;

      // Counter ignores flush: it measures decode back-pressure only.
      if (out_vld && !out_if.ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end

      if (flush) begin
         // head_pc is left alone: out_pc is don't-care while out_valid=0.
         state_d  = EMPTY;
         in_rdy_d = 1'b1;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (acc) begin
                  head_pc_d    = in_if.pc;
                  head_instr_d = in_if.instr;
                  state_d      = BUSY;
               end
            end
            BUSY: begin
               if (acc && cons) begin
                  head_pc_d    = in_if.pc;
                  head_instr_d = in_if.instr;
               end else if (acc) begin
                  skid_pc_d    = in_if.pc;
                  skid_instr_d = in_if.instr;
                  state_d      = FULL;
                  in_rdy_d     = 1'b0;
               end else if (cons) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (cons) begin
                  head_pc_d    = skid_pc_q;
                  head_instr_d = skid_instr_q;
                  state_d      = BUSY;
                  in_rdy_d     = 1'b1;
               end
            end
            default: begin
               state_d  = EMPTY;
               in_rdy_d = 1'b1;
            end
         endcase
      end
   end

   // State, storage and counter registers; reset drops every held beat immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= EMPTY;
         head_pc_q    <= '0;
         head_instr_q <= NOP_INSTR;
         skid_pc_q    <= '0;
         skid_instr_q <= NOP_INSTR;
         in_rdy_q     <= 1'b1;
         stall_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         head_pc_q    <= head_pc_d;
         head_instr_q <= head_instr_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
         in_rdy_q     <= in_rdy_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign in_if.ready  = in_rdy_q;
   assign out_if.valid = out_vld;
   assign out_if.pc    = head_pc_q;
   assign out_if.instr = out_vld ? head_instr_q : NOP_INSTR;
   assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: directed scenarios then random traffic, scored against a queue model.
// Two instances share stimulus: default counter width and a 4-bit counter for saturation.
module tb_if_id_skid_reg;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] in_pc = '0;
   logic [31:0] in_instr = '0;
   logic [15:0] stall16;
   logic [3:0]  stall4;

   always #5 clk = ~clk;

   if_id_skid_reg_if #(.PC_W(32), .INSTR_W(32)) in16 ();
   if_id_skid_reg_if #(.PC_W(32), .INSTR_W(32)) out16 ();
   if_id_skid_reg_if #(.PC_W(32), .INSTR_W(32)) in4 ();
   if_id_skid_reg_if #(.PC_W(32), .INSTR_W(32)) out4 ();

   assign in16.valid  = in_valid;
   assign in16.pc     = in_pc;
   assign in16.instr  = in_instr;
   assign out16.ready = out_ready;
   assign in4.valid   = in_valid;
   assign in4.pc      = in_pc;
   assign in4.instr   = in_instr;
   assign out4.ready  = out_ready;

   if_id_skid_reg #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(NOP), .STALL_CNT_W(16)) u_dut16 (
      .clk(clk), .rst(rst), .in_if(in16), .out_if(out16), .flush(flush), .stall_count(stall16)
   );

   if_id_skid_reg #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(NOP), .STALL_CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_if(in4), .out_if(out4), .flush(flush), .stall_count(stall4)
   );

   // Reference: queue of beats currently held, plus an unbounded stall-cycle count.
   beat_t       exp_q[$];
   int unsigned stall_model = 0;
   int          checks = 0;
   int          errors = 0;
   bit          done = 1'b0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Monitor: compares outputs mid-cycle, then retires the beat decode takes at the next edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!done) begin
            chk("out_valid", 64'(out16.valid), 64'(exp_q.size() > 0));
            chk("out_valid_w4", 64'(out4.valid), 64'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
               chk("out_pc", 64'(out16.pc), 64'(exp_q[0].pc));
               chk("out_instr", 64'(out16.instr), 64'(exp_q[0].instr));
            end else begin
               chk("out_instr_nop", 64'(out16.instr), 64'(NOP));
            end
            if (!rst) chk("reset_out_pc", 64'(out16.pc), 64'd0);
            chk("in_ready", 64'(in16.ready), 64'(exp_q.size() < 2));
            chk("stall_count", 64'(stall16), 64'((stall_model > 65535) ? 65535 : stall_model));
            chk("stall_count_w4", 64'(stall4), 64'((stall_model > 15) ? 15 : stall_model));
            if (rst) begin
               if (exp_q.size() > 0 && !out_ready) stall_model++;
               if (!flush && exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   // One clock of stimulus; the beat accepted at the edge is queued once the monitor is done.
   task automatic drive(input logic r, input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl, input bit arst = 1'b0);
      bit acc;
      @(posedge clk);
      #1;
      rst       = r;
      in_valid  = v;
      in_pc     = pc;
      in_instr  = ins;
      out_ready = ordy;
      flush     = fl;
      if (!r) begin
         exp_q.delete();
         stall_model = 0;
      end
      acc = r && v && !fl && (exp_q.size() < 2);
      if (arst) begin
         #2;
         rst = 1'b0;
         exp_q.delete();
         stall_model = 0;
         acc = 1'b0;
         #1;
         chk("arst_out_valid", 64'(out16.valid), 64'd0);
         chk("arst_in_ready", 64'(in16.ready), 64'd1);
         chk("arst_out_instr", 64'(out16.instr), 64'(NOP));
         chk("arst_out_pc", 64'(out16.pc), 64'd0);
         chk("arst_stall", 64'(stall16), 64'd0);
      end
      @(negedge clk);
      #1;
      if (rst && fl) exp_q.delete();
      else if (acc) exp_q.push_back({pc, ins});
   endtask

   initial begin
      // Reset held two cycles while fetch offers a beat.
      drive(1'b0, 1'b1, 32'h4, 32'h0050_0093, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 32'h4, 32'h0050_0093, 1'b1, 1'b0);

      // Single beat through an empty path.
      drive(1'b1, 1'b1, 32'h4, 32'h0050_0093, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Streaming into back-pressure, then drain.
      drive(1'b1, 1'b1, 32'h4, 32'h0050_0093, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 32'h8, 32'h0010_8133, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 32'hC, 32'h0000_0013, (i >= 3), 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Flush while both entries are held and a beat is offered.
      drive(1'b1, 1'b1, 32'h20, 32'h0020_0113, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 32'h24, 32'h0030_0193, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 32'h28, 32'h0040_0213, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Long stall: the 4-bit counter must pin at 15.
      drive(1'b1, 1'b1, 32'h30, 32'h0050_0293, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Asynchronous reset between edges while FULL, then a fresh beat.
      drive(1'b1, 1'b1, 32'h40, 32'h0060_0313, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 32'h44, 32'h0070_0393, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 32'h48, 32'h0080_0413, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 32'h48, 32'h0080_0413, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 32'h10, 32'h0090_0493, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Random traffic with occasional flushes.
      for (int i = 0; i < 1500; i++) begin
         drive(1'b1, ($urandom_range(0, 9) < 7), {$urandom_range(0, 32'h3FFF), 2'b00}, $urandom(),
               ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0));
      end
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
